ispu_scheduler: RTL and testbench

- Shares one combinational inverse-sigmoid unit (ispu) among NUM_REQ requesters, e.g. the per-neuron backprop lanes.
- Round-robin arbitration selects a requester; its operand is registered into the ispu input, and the result is registered with a requester ID.
- Results go out on a single response channel with valid/ready backpressure.
- Throughput is one operation per cycle; latency is 2 cycles when there is no stall.

---
 rtl/ispu_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/ispu_scheduler.sv | 125 ++++++++++++
 tb/tb_ispu_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ispu_sched_pkg.sv
// Shared types and helpers for the inverse-sigmoid unit scheduler.
// Holds the float word type and the round-robin pointer increment.
package ispu_sched_pkg;

    localparam int FLOAT_W = 32;

    typedef logic [FLOAT_W-1:0] float32_t;

    // Wrap-around increment of a requester index in the range 0..n-1.
    function automatic int next_ptr(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester found at or after ptr.
// Produces a one-hot grant (gated by en) and the grant index.
module rr_arbiter
    import ispu_sched_pkg::*;
#(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic found;

    always_comb begin
        int cand;
        found   = 1'b0;
        gnt_idx = '0;
        cand    = int'(ptr);
        for (int k = 0; k < N; k++) begin
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = W'(cand);
            end
            cand = next_ptr(cand, N);
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_gnt
            assign gnt[gi] = en & found & (gnt_idx == W'(gi));
        end
    endgenerate

endmodule

// File: rtl/ispu_scheduler.sv
// Shares one combinational inverse-sigmoid unit among NUM_REQ requesters
// through a two-stage issue/output pipeline with valid/ready backpressure.
module ispu_scheduler
    import ispu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*FLOAT_W-1:0] req_x_float,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [FLOAT_W-1:0]         ispu_x_float,
    input  logic [FLOAT_W-1:0]         ispu_y_float,
    output logic                       resp_valid,
    output logic [ID_W-1:0]            resp_id,
    output logic [FLOAT_W-1:0]         resp_data,
    input  logic                       resp_ready,
    output logic                       busy
);

    float32_t op_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_op
            assign op_arr[gi] = req_x_float[FLOAT_W*gi +: FLOAT_W];
        end
    endgenerate

    logic            s1_valid_q, s1_valid_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    float32_t        s1_x_q, s1_x_d;
    logic            resp_valid_q, resp_valid_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    float32_t        resp_data_q, resp_data_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic               s2_stall, s1_adv, s1_free, xfer;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    float32_t           op_sel;

    assign s2_stall = resp_valid_q & ~resp_ready;
    assign s1_adv   = s1_valid_q & ~s2_stall;
    assign s1_free  = ~s1_valid_q | s1_adv;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (s1_free),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The grant is already qualified by req_valid, so any grant bit is a transfer.
    assign xfer = |gnt;

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                op_sel = op_arr[i];
            end
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_id_d      = s1_id_q;
        s1_x_d       = s1_x_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        rr_ptr_d     = rr_ptr_q;

        if (s1_adv) begin
            resp_valid_d = 1'b1;
            resp_id_d    = s1_id_q;
            resp_data_d  = ispu_y_float;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end

        if (xfer) begin
            s1_valid_d = 1'b1;
            s1_id_d    = gnt_idx;
            s1_x_d     = op_sel;
            rr_ptr_d   = ID_W'(next_ptr(int'(gnt_idx), NUM_REQ));
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            s1_x_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            rr_ptr_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_x_q       <= s1_x_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign req_ready    = gnt;
    assign ispu_x_float = s1_x_q;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_data    = resp_data_q;
    assign busy         = s1_valid_q | resp_valid_q;

endmodule

// File: tb/tb_ispu_scheduler.sv
// Table-driven bench for ispu_scheduler with an inverting ispu stub,
// plus a randomised-backpressure stream on a single-requester instance.
module tb_ispu_scheduler;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Four-requester instance
    logic [3:0]   r4_req_valid;
    logic [127:0] r4_req_x;
    logic [3:0]   r4_req_ready;
    logic [31:0]  r4_ispu_x, r4_ispu_y;
    logic         r4_resp_valid;
    logic [1:0]   r4_resp_id;
    logic [31:0]  r4_resp_data;
    logic         r4_resp_ready;
    logic         r4_busy;

    assign r4_ispu_y = ~r4_ispu_x;

    ispu_scheduler #(.NUM_REQ(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (r4_req_valid),
        .req_x_float  (r4_req_x),
        .req_ready    (r4_req_ready),
        .ispu_x_float (r4_ispu_x),
        .ispu_y_float (r4_ispu_y),
        .resp_valid   (r4_resp_valid),
        .resp_id      (r4_resp_id),
        .resp_data    (r4_resp_data),
        .resp_ready   (r4_resp_ready),
        .busy         (r4_busy)
    );

    // Single-requester instance
    logic        r1_req_valid;
    logic [31:0] r1_req_x;
    logic        r1_req_ready;
    logic [31:0] r1_ispu_x, r1_ispu_y;
    logic        r1_resp_valid;
    logic        r1_resp_id;
    logic [31:0] r1_resp_data;
    logic        r1_resp_ready;
    logic        r1_busy;

    assign r1_ispu_y = ~r1_ispu_x;

    ispu_scheduler #(.NUM_REQ(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (r1_req_valid),
        .req_x_float  (r1_req_x),
        .req_ready    (r1_req_ready),
        .ispu_x_float (r1_ispu_x),
        .ispu_y_float (r1_ispu_y),
        .resp_valid   (r1_resp_valid),
        .resp_id      (r1_resp_id),
        .resp_data    (r1_resp_data),
        .resp_ready   (r1_resp_ready),
        .busy         (r1_busy)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [31:0] x2;
        logic        rr;
        logic [3:0]  rdy;
        logic        vld;
        logic [1:0]  id;
        logic [31:0] data;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add(input logic r, input logic [3:0] rv, input logic [31:0] x2,
                       input logic rr, input logic [3:0] rdy, input logic vld,
                       input logic [1:0] id, input logic [31:0] data, input logic bsy);
        vec_t v;
        v.rst = r; v.rv = rv; v.x2 = x2; v.rr = rr; v.rdy = rdy;
        v.vld = vld; v.id = id; v.data = data; v.busy = bsy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int got;
        int k;
        logic        prev_stall;
        logic [31:0] prev_data;

        rst = 1'b1;
        r4_req_valid = '0; r4_req_x = '0; r4_resp_ready = 1'b1;
        r1_req_valid = 1'b0; r1_req_x = '0; r1_resp_ready = 1'b1;

        // rst, req_valid, x2, resp_ready | req_ready, resp_valid, resp_id, resp_data, busy
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 0, 0, 32'h0,        0); // reset state
        add(0, 4'b0100, 32'h3F000000, 1, 4'b0100, 0, 0, 32'h0,        0); // single request
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 0, 0, 32'h0,        1);
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 1, 2, 32'hC0FFFFFF, 1);
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 0, 2, 32'hC0FFFFFF, 0);
        add(0, 4'b1001, 32'h2,        1, 4'b1000, 0, 2, 32'hC0FFFFFF, 0); // pointer at 3
        add(0, 4'b0001, 32'h2,        1, 4'b0001, 0, 2, 32'hC0FFFFFF, 1); // wraps to 0
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 1, 3, 32'hFFFFFFFC, 1);
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 1, 0, 32'hFFFFFFFF, 1);
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 0, 0, 32'hFFFFFFFF, 0);
        add(1, 4'b0000, 32'h2,        1, 4'b0000, 0, 0, 32'hFFFFFFFF, 0); // reset pointer
        add(0, 4'b1111, 32'h2,        1, 4'b0001, 0, 0, 32'h0,        0); // continuous stream
        add(0, 4'b1111, 32'h2,        1, 4'b0010, 0, 0, 32'h0,        1);
        add(0, 4'b1111, 32'h2,        1, 4'b0100, 1, 0, 32'hFFFFFFFF, 1);
        add(0, 4'b1111, 32'h2,        1, 4'b1000, 1, 1, 32'hFFFFFFFE, 1);
        add(0, 4'b1111, 32'h2,        1, 4'b0001, 1, 2, 32'hFFFFFFFD, 1);
        for (int i = 0; i < 5; i++)                                         // backpressure
            add(0, 4'b1111, 32'h2,    0, 4'b0000, 1, 3, 32'hFFFFFFFC, 1);
        add(0, 4'b1111, 32'h2,        1, 4'b0010, 1, 3, 32'hFFFFFFFC, 1); // release cycle grant
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 1, 0, 32'hFFFFFFFF, 1);
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 1, 1, 32'hFFFFFFFE, 1);
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 0, 1, 32'hFFFFFFFE, 0);
        add(0, 4'b1111, 32'h2,        1, 4'b0100, 0, 1, 32'hFFFFFFFE, 0); // fill both stages
        add(0, 4'b1111, 32'h2,        1, 4'b1000, 0, 1, 32'hFFFFFFFE, 1);
        add(1, 4'b0000, 32'h2,        0, 4'b0000, 1, 2, 32'hFFFFFFFD, 1); // reset mid-op
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 0, 0, 32'h0,        0);
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 0, 0, 32'h0,        0);
        add(0, 4'b1111, 32'h2,        1, 4'b0001, 0, 0, 32'h0,        0); // pointer back at 0
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 0, 0, 32'h0,        1);
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 1, 0, 32'hFFFFFFFF, 1);
        add(0, 4'b0000, 32'h2,        1, 4'b0000, 0, 0, 32'hFFFFFFFF, 0);

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst           = vecs[i].rst;
            r4_req_valid  = vecs[i].rv;
            r4_req_x      = {32'd3, vecs[i].x2, 32'd1, 32'd0};
            r4_resp_ready = vecs[i].rr;
            @(negedge clk);
            $display("vec %0d: req_ready=%b resp_valid=%b resp_id=%0d resp_data=%h busy=%b",
                     i, r4_req_ready, r4_resp_valid, r4_resp_id, r4_resp_data, r4_busy);
            check($sformatf("v%0d req_ready", i),  {28'd0, r4_req_ready},  {28'd0, vecs[i].rdy});
            check($sformatf("v%0d resp_valid", i), {31'd0, r4_resp_valid}, {31'd0, vecs[i].vld});
            check($sformatf("v%0d resp_id", i),    {30'd0, r4_resp_id},    {30'd0, vecs[i].id});
            check($sformatf("v%0d resp_data", i),  r4_resp_data,           vecs[i].data);
            check($sformatf("v%0d busy", i),       {31'd0, r4_busy},       {31'd0, vecs[i].busy});
        end

        // Single requester: 8 operands under random backpressure, in-order results.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        r4_req_valid = '0;
        got = 0;
        k = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            @(posedge clk);
            #1;
            r1_req_valid  = (k < 8);
            r1_req_x      = 32'h40000000 + 32'(k);
            r1_resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                check("n1 stall stable", r1_resp_data, prev_data);
            end
            if (r1_resp_valid && r1_resp_ready) begin
                $display("n1 resp %0d: id=%0d data=%h", got, r1_resp_id, r1_resp_data);
                check("n1 resp_id", {31'd0, r1_resp_id}, 32'd0);
                check("n1 resp_data", r1_resp_data, ~(32'h40000000 + 32'(got)));
                got++;
            end
            if (r1_req_valid && r1_req_ready) begin
                k++;
            end
            prev_stall = r1_resp_valid && !r1_resp_ready;
            prev_data  = r1_resp_data;
        end
        check("n1 response count", 32'(got), 32'd8);

        @(posedge clk);
        #1;
        r1_req_valid  = 1'b0;
        r1_resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("n1 idle resp_valid", {31'd0, r1_resp_valid}, 32'd0);
        check("n1 idle busy", {31'd0, r1_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
